// File: rtl/pc_redirect_ctrl_if.sv
// Redirect request/response bundle between execute/trap logic and the PC sequencer.
// Purely combinational wiring, no latency of its own.
// Backpressure is carried by hazardStall/pcStall; there is no valid/ready pair here.
interface pc_redirect_ctrl_if #(
  parameter int ADDR_SIZE = 32
);
  logic                 hazardStall;
  logic                 branchReq;
  logic                 branchTaken;
  logic [ADDR_SIZE-1:0] branchTarget;
  logic                 jumpReq;
  logic [ADDR_SIZE-1:0] jumpTargetIn;
  logic                 trapReq;
  logic [ADDR_SIZE-1:0] trapTarget;
  logic [1:0]           selWire;
  logic                 pcStall;
  logic [ADDR_SIZE-1:0] jumpTarget1;
  logic [ADDR_SIZE-1:0] jumpTarget2;
  logic [ADDR_SIZE-1:0] jumpTarget3;
  logic                 flush;
  logic                 misalignErr;
  logic                 busy;

  // Request side: execute/trap logic drives requests and observes PC control.
  modport master (
    output hazardStall, branchReq, branchTaken, branchTarget,
           jumpReq, jumpTargetIn, trapReq, trapTarget,
    input  selWire, pcStall, jumpTarget1, jumpTarget2, jumpTarget3,
           flush, misalignErr, busy
  );

  // Sequencer side.
  modport slave (
    input  hazardStall, branchReq, branchTaken, branchTarget,
           jumpReq, jumpTargetIn, trapReq, trapTarget,
    output selWire, pcStall, jumpTarget1, jumpTarget2, jumpTarget3,
           flush, misalignErr, busy
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Arbitrates trap/branch/jump redirects into the simpleBranch PC unit, then opens a flush window.
// Latency: request at cycle T drives selWire at T+1; PC loads at end of T+1 unless stalled.
// Backpressure: hazardStall freezes the PC and holds the pending redirect/flush count in place.
module pc_redirect_ctrl #(
  parameter int                   ADDR_SIZE    = 32,
  parameter int                   FLUSH_CYCLES = 2,
  parameter bit                   ALIGN_CHECK  = 1'b1,
  parameter logic [ADDR_SIZE-1:0] TRAP_VEC     = 'h80
) (
  input logic               clk,
  input logic               reset,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_TRAP   = 2'd3;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t               state, state_nxt;
  logic [1:0]           pendSel, pendSel_nxt;
  logic [ADDR_SIZE-1:0] pendTarget, pendTarget_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 misErr, misErr_nxt;

  logic                 winVld;
  logic                 winMis;
  logic [1:0]           winSel;
  logic [ADDR_SIZE-1:0] winTarget;

  // Fixed-priority pick among this cycle's requests: trap, then taken branch, then jump.
  always_comb begin
    winVld    = bus.trapReq | (bus.branchReq & bus.branchTaken) | bus.jumpReq;
    winSel    = SEL_JUMP;
    winTarget = bus.jumpTargetIn;
    if (bus.trapReq) begin
      winSel    = SEL_TRAP;
      winTarget = bus.trapTarget;
    end else if (bus.branchReq && bus.branchTaken) begin
      winSel    = SEL_BRANCH;
      winTarget = bus.branchTarget;
    end
    // Trap handler addresses are trusted; only branch/jump targets are checked.
    winMis = ALIGN_CHECK && winVld && (winSel != SEL_TRAP) && (winTarget[1:0] != 2'b00);
  end

  // Next-state and pending-redirect update.
  always_comb begin
    state_nxt      = state;
    pendSel_nxt    = pendSel;
    pendTarget_nxt = pendTarget;
    cnt_nxt        = cnt;
    misErr_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (winVld) begin
          state_nxt = REDIR;
          if (winMis) begin
            pendSel_nxt    = SEL_TRAP;
            pendTarget_nxt = TRAP_VEC;
            misErr_nxt     = 1'b1;
          end else begin
            pendSel_nxt    = winSel;
            pendTarget_nxt = winTarget;
          end
        end
      end
      REDIR: begin
        // A late trap overrides a pending branch/jump even if the PC could load now.
        if (bus.trapReq && (pendSel != SEL_TRAP)) begin
          pendSel_nxt    = SEL_TRAP;
          pendTarget_nxt = bus.trapTarget;
        end else if (!bus.hazardStall) begin
          if (FLUSH_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_INIT;
          end
        end
      end
      FLUSH: begin
        // Branch/jump here belong to the squashed path; only a trap restarts a redirect.
        if (bus.trapReq) begin
          state_nxt      = REDIR;
          pendSel_nxt    = SEL_TRAP;
          pendTarget_nxt = bus.trapTarget;
          cnt_nxt        = 4'd0;
        end else if (!bus.hazardStall) begin
          if (cnt <= 4'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset abandons any redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pendSel    <= 2'd0;
      pendTarget <= '0;
      cnt        <= 4'd0;
      misErr     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pendSel    <= pendSel_nxt;
      pendTarget <= pendTarget_nxt;
      cnt        <= cnt_nxt;
      misErr     <= misErr_nxt;
    end
  end

  assign bus.selWire     = (state == REDIR) ? pendSel : 2'd0;
  assign bus.pcStall     = bus.hazardStall;
  assign bus.jumpTarget1 = pendTarget;
  assign bus.jumpTarget2 = pendTarget;
  assign bus.jumpTarget3 = pendTarget;
  assign bus.flush       = (state != IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.misalignErr = misErr;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency under test: request at T, selWire at T+1, PC load at the end of T+1 when unstalled.
// Backpressure under test: hazardStall holding redirects and flush windows.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hz, br, tk, jr, tr;
  logic [31:0] bt, jt, tt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pc_redirect_ctrl_if #(.ADDR_SIZE(32)) u_if ();
  pc_redirect_ctrl_if #(.ADDR_SIZE(32)) u_if0 ();

  assign u_if.hazardStall  = hz;  assign u_if0.hazardStall  = hz;
  assign u_if.branchReq    = br;  assign u_if0.branchReq    = br;
  assign u_if.branchTaken  = tk;  assign u_if0.branchTaken  = tk;
  assign u_if.branchTarget = bt;  assign u_if0.branchTarget = bt;
  assign u_if.jumpReq      = jr;  assign u_if0.jumpReq      = jr;
  assign u_if.jumpTargetIn = jt;  assign u_if0.jumpTargetIn = jt;
  assign u_if.trapReq      = tr;  assign u_if0.trapReq      = tr;
  assign u_if.trapTarget   = tt;  assign u_if0.trapTarget   = tt;

  pc_redirect_ctrl #(.ADDR_SIZE(32), .FLUSH_CYCLES(2), .ALIGN_CHECK(1'b1), .TRAP_VEC(32'h80))
    dut (.clk(clk), .reset(rst), .bus(u_if.slave));

  pc_redirect_ctrl #(.ADDR_SIZE(32), .FLUSH_CYCLES(2), .ALIGN_CHECK(1'b0), .TRAP_VEC(32'h80))
    dut_noalign (.clk(clk), .reset(rst), .bus(u_if0.slave));

  // Stand-in for the simpleBranch PC register, driven by the DUT's controls.
  logic [31:0] pc;
  always @(posedge clk) begin
    if (!rst) pc <= 32'h0;
    else if (!u_if.pcStall) begin
      case (u_if.selWire)
        2'd0:    pc <= pc + 32'd4;
        2'd1:    pc <= u_if.jumpTarget1;
        2'd2:    pc <= u_if.jumpTarget2;
        default: pc <= u_if.jumpTarget3;
      endcase
    end
  end

  // Behavioural model: is a redirect being presented, of what kind, to where, and how
  // many flush cycles remain after it.
  bit          m_redir;
  int          m_kind;
  int          m_left;
  logic [31:0] m_tgt;
  bit          m_mis;

  always @(posedge clk) begin
    bit mis_now;
    mis_now = 1'b0;
    if (!rst) begin
      m_redir = 0; m_kind = 0; m_left = 0; m_tgt = 0;
    end else if (m_redir) begin
      if (tr && m_kind != 3) begin
        m_kind = 3; m_tgt = tt;
      end else if (!hz) begin
        m_redir = 0; m_left = 2;
      end
    end else if (m_left > 0) begin
      if (tr) begin
        m_redir = 1; m_left = 0; m_kind = 3; m_tgt = tt;
      end else if (!hz) begin
        m_left = m_left - 1;
      end
    end else begin
      if (tr)             begin m_redir = 1; m_kind = 3; m_tgt = tt; end
      else if (br && tk)  begin m_redir = 1; m_kind = 1; m_tgt = bt; end
      else if (jr)        begin m_redir = 1; m_kind = 2; m_tgt = jt; end
      if (m_redir && m_kind != 3 && (m_tgt % 4) != 0) begin
        m_kind = 3; m_tgt = 32'h80; mis_now = 1'b1;
      end
    end
    m_mis = mis_now;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Every cycle, compare all outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_sel",   {30'd0, u_if.selWire}, m_redir ? 32'(m_kind) : 32'd0);
      chk("m_stall", {31'd0, u_if.pcStall}, {31'd0, hz});
      chk("m_flush", {31'd0, u_if.flush},   {31'd0, (m_redir || m_left > 0)});
      chk("m_busy",  {31'd0, u_if.busy},    {31'd0, (m_redir || m_left > 0)});
      chk("m_mis",   {31'd0, u_if.misalignErr}, {31'd0, m_mis});
      chk("m_tgt1",  u_if.jumpTarget1, m_tgt);
      chk("m_tgt3",  u_if.jumpTarget3, m_tgt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz = 0; br = 0; tk = 0; jr = 0; tr = 0;
    bt = 0; jt = 0; tt = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); clr();
    end
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  logic [31:0] p0;

  initial begin
    clr();
    rst = 0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_sel",   {30'd0, u_if.selWire}, 32'd0);
    chk("rst_flush", {31'd0, u_if.flush}, 32'd0);
    chk("rst_busy",  {31'd0, u_if.busy}, 32'd0);
    chk("rst_tgt1",  u_if.jumpTarget1, 32'd0);
    tick(); rst = 1;
    idle(2);

    // T1: taken branch, no stall.
    tick(); clr(); br = 1; tk = 1; bt = 32'h100;
    tick(); clr();
    @(negedge clk);
    chk("t1_sel",   {30'd0, u_if.selWire}, 32'd1);
    chk("t1_tgt1",  u_if.jumpTarget1, 32'h100);
    chk("t1_flush", {31'd0, u_if.flush}, 32'd1);
    tick(); @(negedge clk);
    chk("t1_pc",     pc, 32'h100);
    chk("t1_sel_f",  {30'd0, u_if.selWire}, 32'd0);
    chk("t1_flush1", {31'd0, u_if.flush}, 32'd1);
    tick(); @(negedge clk);
    chk("t1_flush2", {31'd0, u_if.flush}, 32'd1);
    tick(); @(negedge clk);
    chk("t1_done",   {31'd0, u_if.flush}, 32'd0);
    chk("t1_busy",   {31'd0, u_if.busy}, 32'd0);
    idle(2);

    // T2: jump held by three stalled cycles.
    tick(); clr(); jr = 1; jt = 32'h200;
    tick(); clr(); hz = 1;
    @(negedge clk); p0 = pc;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin tick(); clr(); hz = 1; @(negedge clk); end
      chk("t2_sel",   {30'd0, u_if.selWire}, 32'd2);
      chk("t2_stall", {31'd0, u_if.pcStall}, 32'd1);
      chk("t2_pc",    pc, p0);
    end
    tick(); clr();
    @(negedge clk);
    chk("t2_sel_go", {30'd0, u_if.selWire}, 32'd2);
    tick(); @(negedge clk);
    chk("t2_pc_load", pc, 32'h200);
    idle(4);

    // T3: trap beats a simultaneous taken branch.
    tick(); clr(); tr = 1; tt = 32'h400; br = 1; tk = 1; bt = 32'h100;
    tick(); clr();
    @(negedge clk);
    chk("t3_sel",  {30'd0, u_if.selWire}, 32'd3);
    chk("t3_tgt3", u_if.jumpTarget3, 32'h400);
    tick(); @(negedge clk);
    chk("t3_pc", pc, 32'h400);
    idle(4);

    // T4: misaligned jump becomes a trap; pulse lasts one cycle even while stalled.
    tick(); clr(); jr = 1; jt = 32'h102;
    tick(); clr(); hz = 1;
    @(negedge clk);
    chk("t4_sel",     {30'd0, u_if.selWire}, 32'd3);
    chk("t4_tgt3",    u_if.jumpTarget3, 32'h80);
    chk("t4_mis",     {31'd0, u_if.misalignErr}, 32'd1);
    chk("t4_na_sel",  {30'd0, u_if0.selWire}, 32'd2);
    chk("t4_na_tgt2", u_if0.jumpTarget2, 32'h102);
    chk("t4_na_mis",  {31'd0, u_if0.misalignErr}, 32'd0);
    tick(); clr();
    @(negedge clk);
    chk("t4_mis_off", {31'd0, u_if.misalignErr}, 32'd0);
    chk("t4_sel2",    {30'd0, u_if.selWire}, 32'd3);
    tick(); @(negedge clk);
    chk("t4_pc", pc, 32'h80);
    idle(4);

    // T5: branch in the flush window is ignored, trap in it restarts a redirect.
    tick(); clr(); br = 1; tk = 1; bt = 32'h100;
    tick(); clr();
    tick(); clr(); br = 1; tk = 1; bt = 32'h300;
    @(negedge clk); p0 = pc;
    chk("t5_flush", {31'd0, u_if.flush}, 32'd1);
    tick(); clr(); tr = 1; tt = 32'h500;
    @(negedge clk);
    chk("t5_seq", pc, p0 + 32'd4);
    chk("t5_sel0", {30'd0, u_if.selWire}, 32'd0);
    tick(); clr();
    @(negedge clk);
    chk("t5_sel", {30'd0, u_if.selWire}, 32'd3);
    chk("t5_tgt3", u_if.jumpTarget3, 32'h500);
    tick(); @(negedge clk);
    chk("t5_pc", pc, 32'h500);
    chk("t5_flush_new", {31'd0, u_if.flush}, 32'd1);
    idle(4);

    // T6: reset during a stalled redirect abandons it.
    tick(); clr(); jr = 1; jt = 32'h600;
    tick(); clr(); hz = 1; rst = 0;
    tick(); clr(); rst = 1;
    @(negedge clk);
    chk("t6_sel",   {30'd0, u_if.selWire}, 32'd0);
    chk("t6_flush", {31'd0, u_if.flush}, 32'd0);
    chk("t6_busy",  {31'd0, u_if.busy}, 32'd0);
    chk("t6_stall", {31'd0, u_if.pcStall}, 32'd0);
    tick(); @(negedge clk);
    chk("t6_pc",    pc, 32'h4);
    chk("t6_busy2", {31'd0, u_if.busy}, 32'd0);

    // Randomized traffic, checked every cycle by the model compare.
    for (int i = 0; i < 3000; i++) begin
      tick();
      hz  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 3) == 0);
      tk  = $urandom_range(0, 1) != 0;
      jr  = ($urandom_range(0, 4) == 0);
      tr  = ($urandom_range(0, 9) == 0);
      bt  = rnd_tgt();
      jt  = rnd_tgt();
      tt  = $urandom();
      rst = ($urandom_range(0, 99) != 0);
    end
    tick(); clr(); rst = 1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Backstop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
